mem_stage: RTL and testbench

Memory-access pipeline stage directly downstream of the execute stage. Consumes the execute-stage pipeline register (PC, valid, memory op, store data, control op, destination GPR, write enable, exception code, ALU result) and performs word loads/stores over a single-master bus with an address-strobe / ready handshake. It raises `busy` while a bus cycle is outstanding and registers the result into the MEM pipeline register feeding write-back.

---
 rtl/mem_stage.sv | 219 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage that sits directly after the execute stage.
// It issues word loads and stores on a single-master bus using an active-low address
// strobe and an active-low ready handshake. The MEM pipeline register it produces
// feeds the write-back stage.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   stall, flush        hold / bubble the MEM register (from pipeline control)
//   int_detect          interrupt pending: no new access, MEM register bubbles
//   busy                a bus cycle is outstanding; upstream must stall
//   ex_*                EX pipeline register (PC, valid, ctrl fields, mem op, data)
//   mem_fwd_data        combinational stage result, used for forwarding
//   bus_*               address strobe / rw / address / write data / read data / ready
//   mem_*               MEM pipeline register outputs

module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        int_detect,
    output logic        busy,
    input  logic [29:0] ex_pc,
    input  logic        ex_en,
    input  logic        ex_br_flag,
    input  logic [1:0]  ex_ctrl_op,
    input  logic [4:0]  ex_dst_addr,
    input  logic        ex_gpr_we_,
    input  logic [2:0]  ex_exp_code,
    input  logic [1:0]  ex_mem_op,
    input  logic [31:0] ex_mem_wr_data,
    input  logic [31:0] ex_data_out,
    output logic [31:0] mem_fwd_data,
    output logic        bus_as_,
    output logic        bus_rw,
    output logic [29:0] bus_addr,
    output logic [31:0] bus_wr_data,
    input  logic [31:0] bus_rd_data,
    input  logic        bus_rdy_,
    output logic [29:0] mem_pc,
    output logic        mem_en,
    output logic        mem_br_flag,
    output logic [1:0]  mem_ctrl_op,
    output logic [4:0]  mem_dst_addr,
    output logic        mem_gpr_we_,
    output logic [2:0]  mem_exp_code,
    output logic [31:0] mem_out
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [1:0] OP_LDW = 2'd1;
    localparam logic [1:0] OP_STW = 2'd2;

    localparam logic [2:0] EXP_NONE       = 3'h0;
    localparam logic [2:0] EXP_MISS_ALIGN = 3'h3;

    logic [1:0]  state_q, state_d;
    logic        abort_q, abort_d;
    logic        as_q, as_d;
    logic        rw_q, rw_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] rd_buf_q, rd_buf_d;

    logic [29:0] mem_pc_q, mem_pc_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_br_q, mem_br_d;
    logic [1:0]  mem_ctrl_q, mem_ctrl_d;
    logic [4:0]  mem_dst_q, mem_dst_d;
    logic        mem_we_q, mem_we_d;
    logic [2:0]  mem_exp_q, mem_exp_d;
    logic [31:0] mem_out_q, mem_out_d;

    logic        is_mem_op, miss_align, req, kill, drop;
    logic [31:0] result;

    assign is_mem_op  = ex_en & ((ex_mem_op == OP_LDW) | (ex_mem_op == OP_STW));
    assign miss_align = is_mem_op & (ex_data_out[1:0] != 2'b00) & (ex_exp_code == EXP_NONE);
    assign req        = is_mem_op & (ex_data_out[1:0] == 2'b00) & (ex_exp_code == EXP_NONE)
                        & ~int_detect & ~flush;
    assign kill       = flush | int_detect;
    // A flushed access still runs to completion on the bus; its data must not reach
    // the MEM register even after the flush pulse has gone away.
    assign drop       = (state_q == ST_ACCESS) & abort_q;

    always_comb begin
        state_d  = state_q;
        abort_d  = abort_q;
        as_d     = as_q;
        rw_d     = rw_q;
        addr_d   = addr_q;
        wd_d     = wd_q;
        rd_buf_d = rd_buf_q;
        busy     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_ACCESS;
                    busy    = 1'b1;
                    abort_d = 1'b0;
                    as_d    = 1'b0;
                    rw_d    = (ex_mem_op == OP_LDW);
                    addr_d  = ex_data_out[31:2];
                    wd_d    = ex_mem_wr_data;
                end
            end
            ST_ACCESS: begin
                if (bus_rdy_) begin
                    busy = 1'b1;
                    if (kill) abort_d = 1'b1;
                end else begin
                    as_d     = 1'b1;
                    rd_buf_d = bus_rd_data;
                    // Park in DONE only when the result is still wanted but cannot be
                    // accepted yet; this avoids re-issuing the access.
                    if (stall && !kill && !abort_q) state_d = ST_DONE;
                    else                            state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (!stall || kill) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        result = ex_data_out;
        case (state_q)
            ST_ACCESS: if (rw_q) result = bus_rd_data;
            ST_DONE:   if (rw_q) result = rd_buf_q;
            default:   if (miss_align) result = '0;
        endcase
    end

    always_comb begin
        mem_pc_d   = mem_pc_q;
        mem_en_d   = mem_en_q;
        mem_br_d   = mem_br_q;
        mem_ctrl_d = mem_ctrl_q;
        mem_dst_d  = mem_dst_q;
        mem_we_d   = mem_we_q;
        mem_exp_d  = mem_exp_q;
        mem_out_d  = mem_out_q;
        if (kill || (!stall && (busy || drop))) begin
            mem_pc_d   = '0;
            mem_en_d   = 1'b0;
            mem_br_d   = 1'b0;
            mem_ctrl_d = '0;
            mem_dst_d  = '0;
            mem_we_d   = 1'b1;
            mem_exp_d  = '0;
            mem_out_d  = '0;
        end else if (!stall) begin
            mem_pc_d   = ex_pc;
            mem_en_d   = ex_en;
            mem_br_d   = ex_br_flag;
            mem_ctrl_d = ex_ctrl_op;
            mem_dst_d  = ex_dst_addr;
            mem_we_d   = ex_gpr_we_ | miss_align;
            mem_exp_d  = miss_align ? EXP_MISS_ALIGN : ex_exp_code;
            mem_out_d  = result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            abort_q    <= 1'b0;
            as_q       <= 1'b1;
            rw_q       <= 1'b1;
            addr_q     <= '0;
            wd_q       <= '0;
            rd_buf_q   <= '0;
            mem_pc_q   <= '0;
            mem_en_q   <= 1'b0;
            mem_br_q   <= 1'b0;
            mem_ctrl_q <= '0;
            mem_dst_q  <= '0;
            mem_we_q   <= 1'b1;
            mem_exp_q  <= '0;
            mem_out_q  <= '0;
        end else begin
            state_q    <= state_d;
            abort_q    <= abort_d;
            as_q       <= as_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            wd_q       <= wd_d;
            rd_buf_q   <= rd_buf_d;
            mem_pc_q   <= mem_pc_d;
            mem_en_q   <= mem_en_d;
            mem_br_q   <= mem_br_d;
            mem_ctrl_q <= mem_ctrl_d;
            mem_dst_q  <= mem_dst_d;
            mem_we_q   <= mem_we_d;
            mem_exp_q  <= mem_exp_d;
            mem_out_q  <= mem_out_d;
        end
    end

    assign mem_fwd_data = result;
    assign bus_as_      = as_q;
    assign bus_rw       = rw_q;
    assign bus_addr     = addr_q;
    assign bus_wr_data  = wd_q;
    assign mem_pc       = mem_pc_q;
    assign mem_en       = mem_en_q;
    assign mem_br_flag  = mem_br_q;
    assign mem_ctrl_op  = mem_ctrl_q;
    assign mem_dst_addr = mem_dst_q;
    assign mem_gpr_we_  = mem_we_q;
    assign mem_exp_code = mem_exp_q;
    assign mem_out      = mem_out_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, int_detect, busy;
    logic [29:0] ex_pc;
    logic        ex_en, ex_br_flag, ex_gpr_we_;
    logic [1:0]  ex_ctrl_op, ex_mem_op;
    logic [4:0]  ex_dst_addr;
    logic [2:0]  ex_exp_code;
    logic [31:0] ex_mem_wr_data, ex_data_out, mem_fwd_data;
    logic        bus_as_, bus_rw, bus_rdy_;
    logic [29:0] bus_addr;
    logic [31:0] bus_wr_data, bus_rd_data;
    logic [29:0] mem_pc;
    logic        mem_en, mem_br_flag, mem_gpr_we_;
    logic [1:0]  mem_ctrl_op;
    logic [4:0]  mem_dst_addr;
    logic [2:0]  mem_exp_code;
    logic [31:0] mem_out;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .int_detect(int_detect),
        .busy(busy), .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag),
        .ex_ctrl_op(ex_ctrl_op), .ex_dst_addr(ex_dst_addr), .ex_gpr_we_(ex_gpr_we_),
        .ex_exp_code(ex_exp_code), .ex_mem_op(ex_mem_op), .ex_mem_wr_data(ex_mem_wr_data),
        .ex_data_out(ex_data_out), .mem_fwd_data(mem_fwd_data), .bus_as_(bus_as_),
        .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
        .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_), .mem_pc(mem_pc), .mem_en(mem_en),
        .mem_br_flag(mem_br_flag), .mem_ctrl_op(mem_ctrl_op), .mem_dst_addr(mem_dst_addr),
        .mem_gpr_we_(mem_gpr_we_), .mem_exp_code(mem_exp_code), .mem_out(mem_out)
    );

    typedef struct packed {
        logic [29:0] pc;
        logic        en;
        logic        br;
        logic [1:0]  ctrl;
        logic [4:0]  dst;
        logic        we_;
        logic [2:0]  exp;
        logic [1:0]  op;
        logic [31:0] wd;
        logic [31:0] dout;
    } ex_t;

    typedef struct packed {
        logic [29:0] pc;
        logic        en;
        logic        br;
        logic [1:0]  ctrl;
        logic [4:0]  dst;
        logic        we_;
        logic [2:0]  exp;
        logic [31:0] out;
    } mem_reg_t;

    localparam mem_reg_t BUBBLE = '{pc: '0, en: 1'b0, br: 1'b0, ctrl: '0, dst: '0,
                                    we_: 1'b1, exp: '0, out: '0};
    localparam ex_t IDLE_EX = '{pc: '0, en: 1'b0, br: 1'b0, ctrl: '0, dst: '0,
                                we_: 1'b1, exp: '0, op: '0, wd: '0, dout: '0};

    mem_reg_t    dut_reg;
    assign dut_reg = {mem_pc, mem_en, mem_br_flag, mem_ctrl_op, mem_dst_addr,
                      mem_gpr_we_, mem_exp_code, mem_out};

    int          checks = 0;
    int          fails  = 0;
    logic [31:0] mem_model [16];

    // Reference: what the MEM register should hold once an instruction retires here.
    function automatic mem_reg_t expect_reg(input ex_t e, input logic [31:0] rd);
        mem_reg_t r;
        r = '{pc: e.pc, en: e.en, br: e.br, ctrl: e.ctrl, dst: e.dst,
              we_: e.we_, exp: e.exp, out: e.dout};
        if (e.en && (e.op == 2'd1 || e.op == 2'd2) && e.exp == 3'd0 && e.dout[1:0] != 2'd0) begin
            r.exp = 3'h3;
            r.we_ = 1'b1;
            r.out = '0;
        end else if (e.en && e.op == 2'd1 && e.exp == 3'd0) begin
            r.out = rd;
        end
        return r;
    endfunction

    function automatic ex_t rand_ex(input logic [1:0] op, input logic [31:0] dout);
        ex_t e;
        e.pc   = 30'($urandom);
        e.en   = (op != 2'd0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        e.br   = 1'($urandom);
        e.ctrl = 2'($urandom);
        e.dst  = 5'($urandom);
        e.we_  = 1'($urandom);
        e.exp  = (op != 2'd0) ? 3'd0 : 3'($urandom);
        e.op   = op;
        e.wd   = $urandom;
        e.dout = dout;
        return e;
    endfunction

    task automatic apply(input ex_t e);
        ex_pc = e.pc; ex_en = e.en; ex_br_flag = e.br; ex_ctrl_op = e.ctrl;
        ex_dst_addr = e.dst; ex_gpr_we_ = e.we_; ex_exp_code = e.exp;
        ex_mem_op = e.op; ex_mem_wr_data = e.wd; ex_data_out = e.dout;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        apply(rand_ex(2'd0, 32'h0BAD_0BAD));
        tick();
        tick();
        checks++;
        if ({bus_as_, bus_rw, bus_addr, bus_wr_data, busy} !== {1'b1, 1'b1, 30'd0, 32'd0, 1'b0}) begin
            fails++;
            $display("FAIL reset_bus: got as=%b rw=%b addr=%h wd=%h busy=%b, expected 1 1 0 0 0",
                     bus_as_, bus_rw, bus_addr, bus_wr_data, busy);
        end
        checks++;
        if (dut_reg !== BUBBLE) begin
            fails++;
            $display("FAIL reset_reg: got %h expected %h", dut_reg, BUBBLE);
        end
        rst = 1'b0;
        apply(IDLE_EX);
    endtask

    task automatic test_alu();
        ex_t e;
        for (int i = 0; i < 16; i++) begin
            e = rand_ex(2'd0, (i == 0) ? 32'h0000_1234 : $urandom);
            if (i == 0) e.en = 1'b1;
            apply(e);
            @(negedge clk);
            checks++;
            if ({busy, bus_as_, mem_fwd_data} !== {1'b0, 1'b1, e.dout}) begin
                fails++;
                $display("FAIL alu_comb[%0d]: got busy=%b as=%b fwd=%h, expected 0 1 %h",
                         i, busy, bus_as_, mem_fwd_data, e.dout);
            end
            tick();
            checks++;
            if (dut_reg !== expect_reg(e, 32'd0)) begin
                fails++;
                $display("FAIL alu_reg[%0d]: got %h expected %h", i, dut_reg, expect_reg(e, 32'd0));
            end
        end
        apply(IDLE_EX);
    endtask

    task automatic do_access(input ex_t e, input int unsigned waits, input logic [31:0] rd);
        int unsigned strobes = 0;
        logic        is_ld = (e.op == 2'd1);
        mem_reg_t    want = expect_reg(e, rd);
        apply(e);
        bus_rdy_ = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, bus_as_} !== 2'b11) begin
            fails++;
            $display("FAIL acc_issue: got busy=%b as=%b, expected 1 1", busy, bus_as_);
        end
        tick();
        checks++;
        if (dut_reg !== BUBBLE) begin
            fails++;
            $display("FAIL acc_issue_bubble: got %h expected %h", dut_reg, BUBBLE);
        end
        for (int w = 0; w < int'(waits); w++) begin
            bus_rd_data = $urandom;
            @(negedge clk);
            if (!bus_as_) strobes++;
            checks++;
            if ({busy, bus_rw, bus_addr, bus_wr_data} !== {1'b1, is_ld, e.dout[31:2], e.wd}) begin
                fails++;
                $display("FAIL acc_wait: got busy=%b rw=%b addr=%h wd=%h, expected 1 %b %h %h",
                         busy, bus_rw, bus_addr, bus_wr_data, is_ld, e.dout[31:2], e.wd);
            end
            tick();
            checks++;
            if (dut_reg !== BUBBLE) begin
                fails++;
                $display("FAIL acc_wait_bubble: got %h expected %h", dut_reg, BUBBLE);
            end
        end
        bus_rdy_ = 1'b0;
        bus_rd_data = rd;
        @(negedge clk);
        if (!bus_as_) strobes++;
        checks++;
        if ({busy, bus_rw, bus_addr, bus_wr_data, mem_fwd_data} !==
            {1'b0, is_ld, e.dout[31:2], e.wd, want.out}) begin
            fails++;
            $display("FAIL acc_rdy: got busy=%b rw=%b addr=%h wd=%h fwd=%h, expected 0 %b %h %h %h",
                     busy, bus_rw, bus_addr, bus_wr_data, mem_fwd_data,
                     is_ld, e.dout[31:2], e.wd, want.out);
        end
        tick();
        bus_rdy_ = 1'b1;
        bus_rd_data = $urandom;
        checks++;
        if (dut_reg !== want) begin
            fails++;
            $display("FAIL acc_result: got %h expected %h", dut_reg, want);
        end
        checks++;
        if (strobes !== waits + 1) begin
            fails++;
            $display("FAIL acc_strobes: got %0d expected %0d", strobes, waits + 1);
        end
        apply(IDLE_EX);
        @(negedge clk);
        checks++;
        if ({busy, bus_as_} !== 2'b01) begin
            fails++;
            $display("FAIL acc_after: got busy=%b as=%b, expected 0 1", busy, bus_as_);
        end
        tick();
    endtask

    task automatic test_load_store();
        ex_t         e;
        int unsigned idx, waits;
        logic [31:0] rd;
        e = rand_ex(2'd1, 32'h0000_0100);
        do_access(e, 0, 32'hDEAD_BEEF);
        e = rand_ex(2'd2, 32'h0000_0204);
        e.wd = 32'hCAFE_F00D;
        do_access(e, 3, $urandom);
        for (int i = 0; i < 24; i++) begin
            idx   = $urandom_range(0, 15);
            waits = $urandom_range(0, 3);
            e     = rand_ex(2'($urandom_range(1, 2)), 32'h100 + idx * 4);
            rd    = (e.op == 2'd1) ? mem_model[idx] : $urandom;
            do_access(e, waits, rd);
            if (e.op == 2'd2) mem_model[idx] = e.wd;
        end
    endtask

    task automatic test_misalign();
        ex_t e;
        for (int i = 0; i < 6; i++) begin
            e = rand_ex((i % 2 == 0) ? 2'd1 : 2'd2,
                        (i == 0) ? 32'h0000_0102 : (($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3))));
            apply(e);
            @(negedge clk);
            checks++;
            if ({busy, bus_as_, mem_fwd_data} !== {1'b0, 1'b1, 32'd0}) begin
                fails++;
                $display("FAIL misalign_comb[%0d]: got busy=%b as=%b fwd=%h, expected 0 1 0",
                         i, busy, bus_as_, mem_fwd_data);
            end
            tick();
            checks++;
            if (dut_reg !== expect_reg(e, 32'd0)) begin
                fails++;
                $display("FAIL misalign_reg[%0d]: got %h expected %h", i, dut_reg, expect_reg(e, 32'd0));
            end
        end
        apply(IDLE_EX);
    endtask

    task automatic test_stall_done();
        ex_t e;
        int  strobes = 0;
        e = rand_ex(2'd1, 32'h0000_0308);
        apply(e);
        tick();
        stall = 1'b1;
        bus_rdy_ = 1'b0;
        bus_rd_data = 32'h55AA_55AA;
        @(negedge clk);
        if (!bus_as_) strobes++;
        tick();
        bus_rdy_ = 1'b1;
        bus_rd_data = 32'h1234_5678;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) stall = 1'b0;
            @(negedge clk);
            if (!bus_as_) strobes++;
            checks++;
            if ({busy, mem_fwd_data} !== {1'b0, 32'h55AA_55AA}) begin
                fails++;
                $display("FAIL done_comb[%0d]: got busy=%b fwd=%h, expected 0 55aa55aa", c, busy, mem_fwd_data);
            end
            tick();
            if (c < 2) begin
                checks++;
                if (dut_reg !== BUBBLE) begin
                    fails++;
                    $display("FAIL done_hold[%0d]: got %h expected %h", c, dut_reg, BUBBLE);
                end
            end
        end
        checks++;
        if (dut_reg !== expect_reg(e, 32'h55AA_55AA)) begin
            fails++;
            $display("FAIL done_result: got %h expected %h", dut_reg, expect_reg(e, 32'h55AA_55AA));
        end
        checks++;
        if (strobes !== 1) begin
            fails++;
            $display("FAIL done_strobes: got %0d expected 1", strobes);
        end
        apply(IDLE_EX);
        tick();
    endtask

    task automatic test_flush_access();
        ex_t e;
        e = rand_ex(2'd1, 32'h0000_0040);
        apply(e);
        tick();
        for (int c = 0; c < 3; c++) begin
            flush = (c == 0);
            bus_rdy_ = (c != 2) ? 1'b1 : 1'b0;
            bus_rd_data = $urandom;
            @(negedge clk);
            checks++;
            if ({busy, bus_as_} !== {(c != 2), 1'b0}) begin
                fails++;
                $display("FAIL flush_bus[%0d]: got busy=%b as=%b, expected %b 0", c, busy, bus_as_, (c != 2));
            end
            tick();
            checks++;
            if (dut_reg !== BUBBLE) begin
                fails++;
                $display("FAIL flush_reg[%0d]: got %h expected %h", c, dut_reg, BUBBLE);
            end
        end
        flush = 1'b0;
        bus_rdy_ = 1'b1;
        e = rand_ex(2'd0, $urandom);
        apply(e);
        @(negedge clk);
        checks++;
        if ({busy, bus_as_} !== 2'b01) begin
            fails++;
            $display("FAIL flush_after: got busy=%b as=%b, expected 0 1", busy, bus_as_);
        end
        tick();
        checks++;
        if (dut_reg !== expect_reg(e, 32'd0)) begin
            fails++;
            $display("FAIL flush_next: got %h expected %h", dut_reg, expect_reg(e, 32'd0));
        end
        apply(IDLE_EX);
    endtask

    task automatic test_ctrl();
        ex_t e1, e2;
        e1 = rand_ex(2'd0, $urandom);
        e1.en = 1'b1;
        apply(e1);
        tick();
        e2 = rand_ex(2'd0, $urandom);
        apply(e2);
        stall = 1'b1;
        tick();
        checks++;
        if (dut_reg !== expect_reg(e1, 32'd0)) begin
            fails++;
            $display("FAIL stall_hold: got %h expected %h", dut_reg, expect_reg(e1, 32'd0));
        end
        flush = 1'b1;
        tick();
        checks++;
        if (dut_reg !== BUBBLE) begin
            fails++;
            $display("FAIL flush_bubble: got %h expected %h", dut_reg, BUBBLE);
        end
        stall = 1'b0;
        flush = 1'b0;
        int_detect = 1'b1;
        apply(rand_ex(2'd1, 32'h0000_0080));
        @(negedge clk);
        checks++;
        if ({busy, bus_as_} !== 2'b01) begin
            fails++;
            $display("FAIL int_comb: got busy=%b as=%b, expected 0 1", busy, bus_as_);
        end
        tick();
        int_detect = 1'b0;
        apply(IDLE_EX);
        @(negedge clk);
        checks++;
        if ({bus_as_, dut_reg} !== {1'b1, BUBBLE}) begin
            fails++;
            $display("FAIL int_no_access: got as=%b reg=%h, expected 1 %h", bus_as_, dut_reg, BUBBLE);
        end
        tick();
    endtask

    task automatic test_rst_mid();
        ex_t e;
        e = rand_ex(2'd2, 32'h0000_0ABC);
        apply(e);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        apply(IDLE_EX);
        @(negedge clk);
        checks++;
        if ({bus_as_, bus_rw, bus_addr, bus_wr_data, busy} !== {1'b1, 1'b1, 30'd0, 32'd0, 1'b0}) begin
            fails++;
            $display("FAIL rst_mid_bus: got as=%b rw=%b addr=%h wd=%h busy=%b, expected 1 1 0 0 0",
                     bus_as_, bus_rw, bus_addr, bus_wr_data, busy);
        end
        checks++;
        if (dut_reg !== BUBBLE) begin
            fails++;
            $display("FAIL rst_mid_reg: got %h expected %h", dut_reg, BUBBLE);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; int_detect = 1'b0;
        bus_rdy_ = 1'b1; bus_rd_data = '0;
        apply(IDLE_EX);
        for (int i = 0; i < 16; i++) mem_model[i] = $urandom;
        test_reset();
        test_alu();
        test_load_store();
        test_misalign();
        test_stall_done();
        test_flush_access();
        test_ctrl();
        test_rst_mid();
        test_alu();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
